ex_muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit for the execute stage. Executes MUL/MULH/MULHSU/MULHU/
//   DIV/DIVU/REM/REMU over multiple cycles and stalls the pipeline while busy. It sits beside the

---
 rtl/ex_muldiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN swaps the multiply iteration for a single-cycle multiplier.
module ex_muldiv_unit #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 5,
    parameter int unsigned FUNCT_WIDTH = 3
) (
    input  logic                   md_clk,
    input  logic                   md_rst,
    input  logic                   md_i_start,
    input  logic [FUNCT_WIDTH-1:0] md_i_funct3,
    input  logic [DWIDTH-1:0]      md_i_data_rs1,
    input  logic [DWIDTH-1:0]      md_i_data_rs2,
    input  logic [AWIDTH-1:0]      md_i_addr_rd,
    input  logic                   md_i_flush,
    output logic                   md_o_busy,
    output logic                   md_o_stall,
    output logic                   md_o_valid,
    output logic [DWIDTH-1:0]      md_o_data_rd,
    output logic [AWIDTH-1:0]      md_o_addr_rd
);

    localparam int unsigned CW = $clog2(DWIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DWIDTH);

    localparam logic [FUNCT_WIDTH-1:0] OP_MULH   = FUNCT_WIDTH'(1);
    localparam logic [FUNCT_WIDTH-1:0] OP_MULHSU = FUNCT_WIDTH'(2);
    localparam logic [FUNCT_WIDTH-1:0] OP_DIV    = FUNCT_WIDTH'(4);
    localparam logic [FUNCT_WIDTH-1:0] OP_REM    = FUNCT_WIDTH'(6);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t                   state_q, state_d;
    logic [FUNCT_WIDTH-1:0]   op_q;
    logic [AWIDTH-1:0]        rd_q;
    logic [DWIDTH-1:0]        mag_a_q, mag_b_q;
    logic                     neg_res_q, neg_rem_q;
    logic [CW-1:0]            cnt_q;
    logic [2*DWIDTH-1:0]      acc_q;
    logic [DWIDTH:0]          rem_q;
    logic [DWIDTH-1:0]        quo_q;
    logic [DWIDTH-1:0]        data_q;
    logic [AWIDTH-1:0]        addr_q;

    // Two's-complement magnitude product, sign-corrected, then half selected by funct3[1:0].
    function automatic logic [DWIDTH-1:0] mul_result(input logic [2*DWIDTH-1:0] mag,
                                                     input logic neg,
                                                     input logic [1:0] sel);
        logic [2*DWIDTH-1:0] prod;
        prod = neg ? (~mag + 1'b1) : mag;
        return (sel == 2'd0) ? prod[DWIDTH-1:0] : prod[2*DWIDTH-1:DWIDTH];
    endfunction

    // Operand decode at the request
    logic                a_signed, b_signed, sign_a, sign_b;
    logic [DWIDTH-1:0]   mag_a, mag_b;
    logic                div_by_zero, div_ovf, start_acc;
    logic [DWIDTH-1:0]   res_fast;
    logic                take_fast;

    always_comb begin
        a_signed = (md_i_funct3 == OP_MULH) || (md_i_funct3 == OP_MULHSU) ||
                   (md_i_funct3 == OP_DIV) || (md_i_funct3 == OP_REM);
        b_signed = (md_i_funct3 == OP_MULH) || (md_i_funct3 == OP_DIV) ||
                   (md_i_funct3 == OP_REM);
        sign_a = a_signed & md_i_data_rs1[DWIDTH-1];
        sign_b = b_signed & md_i_data_rs2[DWIDTH-1];
        mag_a = sign_a ? (~md_i_data_rs1 + 1'b1) : md_i_data_rs1;
        mag_b = sign_b ? (~md_i_data_rs2 + 1'b1) : md_i_data_rs2;
        div_by_zero = md_i_funct3[2] && (md_i_data_rs2 == '0);
        div_ovf = ((md_i_funct3 == OP_DIV) || (md_i_funct3 == OP_REM)) &&
                  (md_i_data_rs1 == {1'b1, {(DWIDTH-1){1'b0}}}) && (md_i_data_rs2 == '1);
        start_acc = (state_q == StIdle) && md_i_start && !md_i_flush;
    end

    // Results that need no iteration; funct3[1] separates REM* from DIV*
    always_comb begin
        res_fast  = '0;
        take_fast = 1'b0;
        if (div_by_zero) begin
            res_fast  = md_i_funct3[1] ? md_i_data_rs1 : '1;
            take_fast = 1'b1;
        end else if (div_ovf) begin
            res_fast  = md_i_funct3[1] ? '0 : md_i_data_rs1;
            take_fast = 1'b1;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!md_i_funct3[2]) begin
            res_fast  = mul_result({{DWIDTH{1'b0}}, mag_a} * {{DWIDTH{1'b0}}, mag_b},
                                   sign_a ^ sign_b, md_i_funct3[1:0]);
            take_fast = 1'b1;
        end
`endif
    end

    // One iteration step for each algorithm
    logic [DWIDTH:0]     mul_sum;
    logic [2*DWIDTH-1:0] acc_next;
    logic [DWIDTH+1:0]   div_shift, div_diff;
    logic                div_ge;
    logic [DWIDTH:0]     rem_next;
    logic [DWIDTH-1:0]   quo_next;
    logic [DWIDTH-1:0]   res_calc;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        acc_next  = {mul_sum, acc_q[DWIDTH-1:1]};
        div_shift = {rem_q, quo_q[DWIDTH-1]};
        div_diff  = div_shift - {2'b00, mag_b_q};
        div_ge    = ~div_diff[DWIDTH+1];
        rem_next  = div_ge ? div_diff[DWIDTH:0] : div_shift[DWIDTH:0];
        quo_next  = {quo_q[DWIDTH-2:0], div_ge};
    end

    always_comb begin
        res_calc = mul_result(acc_q, neg_res_q, op_q[1:0]);
        if (op_q[2]) begin
            if (op_q[1]) begin
                res_calc = neg_rem_q ? (~rem_q[DWIDTH-1:0] + 1'b1) : rem_q[DWIDTH-1:0];
            end else begin
                res_calc = neg_res_q ? (~quo_q + 1'b1) : quo_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d = take_fast ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == LAST_COUNT) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (md_i_flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge md_clk or posedge md_rst) begin
        if (md_rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rd_q      <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            data_q    <= '0;
            addr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                op_q      <= md_i_funct3;
                rd_q      <= md_i_addr_rd;
                mag_a_q   <= mag_a;
                mag_b_q   <= mag_b;
                neg_res_q <= sign_a ^ sign_b;
                neg_rem_q <= sign_a;
                cnt_q     <= '0;
                acc_q     <= {{DWIDTH{1'b0}}, mag_b};
                rem_q     <= '0;
                quo_q     <= mag_a;
            end else if ((state_q == StCalc) && (cnt_q != LAST_COUNT)) begin
                cnt_q <= cnt_q + 1'b1;
                if (op_q[2]) begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                end else begin
                    acc_q <= acc_next;
                end
            end
            // Result registers load on entry to DONE so valid and data appear together
            if ((state_d == StDone) && (state_q != StDone)) begin
                data_q <= (state_q == StIdle) ? res_fast : res_calc;
                addr_q <= (state_q == StIdle) ? md_i_addr_rd : rd_q;
            end
        end
    end

    assign md_o_busy    = (state_q != StIdle);
    assign md_o_stall   = ((state_q == StIdle) && md_i_start) || (state_q == StCalc);
    assign md_o_valid   = (state_q == StDone);
    assign md_o_data_rd = data_q;
    assign md_o_addr_rd = addr_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M vectors, flush and mid-operation reset.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_ex_muldiv_unit;

    localparam int DW = 32;
    localparam int CALC_LAT = DW + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = CALC_LAT;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, stall, valid;
    logic [31:0] data_out;
    logic [4:0]  addr_out;

    ex_muldiv_unit #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3)) dut (
        .md_clk        (clk),
        .md_rst        (rst),
        .md_i_start    (start),
        .md_i_funct3   (funct3),
        .md_i_data_rs1 (rs1),
        .md_i_data_rs2 (rs2),
        .md_i_addr_rd  (rd_in),
        .md_i_flush    (flush),
        .md_o_busy     (busy),
        .md_o_stall    (stall),
        .md_o_valid    (valid),
        .md_o_data_rd  (data_out),
        .md_o_addr_rd  (addr_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          e0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every valid strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                check("valid_without_request", {31'b0, valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("data_rd", data_out, e.data);
                check("addr_rd", {27'b0, addr_out}, {27'b0, e.rd});
                check("latency", cyc - e.e0, e.lat);
                check("stall_in_valid", {31'b0, stall}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data, input int lat,
                         input bit track, output int e0);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_issue", {31'b0, busy}, 32'd0);
        funct3 = f;
        rs1 = a;
        rs2 = b;
        rd_in = rd;
        start = 1'b1;
        #1;
        check("stall_on_start", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        e0 = cyc;
        if (track) sb.push_back('{exp_data, rd, e0, lat});
        check("busy_after_start", {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        if (lat > 0) check("stall_in_calc", {31'b0, stall}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("result_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        bit          sp;
    } vec_t;

    vec_t vecs [17] = '{
        '{3'd0, 32'd7,          32'd6,          32'h0000002A, 1'b0},
        '{3'd1, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF, 1'b0},
        '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 1'b0},
        '{3'd2, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF, 1'b0},
        '{3'd0, 32'h12345678,   32'h00000010,   32'h23456780, 1'b0},
        '{3'd0, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1, 1'b0},
        '{3'd1, 32'h80000000,   32'h80000000,   32'h40000000, 1'b0},
        '{3'd3, 32'h80000000,   32'd4,          32'h00000002, 1'b0},
        '{3'd4, 32'hFFFFFFEC,   32'd3,          32'hFFFFFFFA, 1'b0},
        '{3'd6, 32'hFFFFFFEC,   32'd3,          32'hFFFFFFFE, 1'b0},
        '{3'd5, 32'd100,        32'd7,          32'd14,       1'b0},
        '{3'd7, 32'd100,        32'd7,          32'd2,        1'b0},
        '{3'd4, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 1'b0},
        '{3'd5, 32'd5,          32'd0,          32'hFFFFFFFF, 1'b1},
        '{3'd6, 32'd5,          32'd0,          32'd5,        1'b1},
        '{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1},
        '{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'd0,        1'b1}
    };

    initial begin
        int e0;
        int lat;
        logic [31:0] last_data;

        repeat (2) @(negedge clk);
        check("reset_busy",  {31'b0, busy},  32'd0);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_data",  data_out, 32'd0);
        check("reset_addr",  {27'b0, addr_out}, 32'd0);
        rst = 1'b0;

        last_data = '0;
        for (int i = 0; i < 17; i++) begin
            lat = vecs[i].sp ? 0 : (vecs[i].f[2] ? CALC_LAT : MUL_LAT);
            issue(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp_data, lat, 1'b1, e0);
            drain();
            last_data = vecs[i].exp_data;
        end

        // Flush a divide mid-iteration: no result, data_rd keeps the previous value
        issue(3'd4, 32'd100, 32'd7, 5'd9, 32'd0, CALC_LAT, 1'b0, e0);
        while (cyc < e0 + 9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        check("flush_data_kept", data_out, last_data);
        check("flush_idle", {31'b0, busy}, 32'd0);
        issue(3'd0, 32'd3, 32'd3, 5'd12, 32'd9, MUL_LAT, 1'b1, e0);
        drain();

        // Reset mid-operation clears everything at once
        issue(3'd5, 32'd1000, 32'd10, 5'd13, 32'd0, CALC_LAT, 1'b0, e0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy",  {31'b0, busy},  32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_data",  data_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 5'd14, 32'd14, CALC_LAT, 1'b1, e0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
